// File: rtl/bcd_timer_pkg.sv
// Shared constants and helpers for the BCD timer: seven-segment patterns,
// decimal-to-BCD conversion and prescaler width sizing.
package bcd_timer_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low patterns, bit 6 = g ... bit 0 = a
  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  function automatic logic [31:0] to_bcd(input int value, input int digits);
    logic [31:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < 8; i++) begin
      if (i < digits) begin
        r[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Single-digit BCD to active-low seven-segment decoder; codes above 9 blank.
module seg7_dec
  import bcd_timer_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_DIGITS[bcd];
  end

endmodule

// File: rtl/bcd_timer.sv
// N-digit BCD up/down timer with clock-enable prescaler and segment outputs.
// Optional build macro BCD_TIMER_AUTO_RELOAD_EN: wrap at terminal, done pulses.
module bcd_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int DIV       = 6000000,
  parameter int MAX_COUNT = 99
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic                dir,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] bcd,
  output logic [7*DIGITS-1:0] seg,
  output logic                done,
  output logic                tick
);

  localparam int             W          = 4 * DIGITS;
  localparam int             PW         = presc_width(DIV);
  localparam logic [31:0]    MAX_BCD32  = to_bcd(MAX_COUNT, DIGITS);
  localparam logic [W-1:0]   MAX_BCD    = MAX_BCD32[W-1:0];
  localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;
  logic [W-1:0]  bcd_q;
  logic          term_flag;
  logic          tick_q;
  logic          dir_q;

  logic [W-1:0]  load_sat;
  logic [W-1:0]  load_eff;
  logic [W-1:0]  step_val;
  logic          step_term;
  logic          step_ok;
  logic          presc_wrap;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic carry;
    r = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic borrow;
    r = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Valid BCD orders the same as binary, so plain compares work on bcd_q.
  always_comb begin
    load_sat = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_sat[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
    load_eff = (!dir && (load_sat > MAX_BCD)) ? MAX_BCD : load_sat;

    presc_wrap = (presc == PRESC_LAST);
    step_ok    = en && tick_q;

    step_val  = bcd_q;
    step_term = term_flag;
    if (!dir) begin
      if (bcd_q > MAX_BCD) begin
        step_val  = MAX_BCD;
        step_term = 1'b1;
      end else if (bcd_q != MAX_BCD) begin
        step_val  = bcd_inc(bcd_q);
        step_term = (step_val == MAX_BCD);
      end else if (!term_flag) step_term = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      else begin
        step_val  = '0;
        step_term = 1'b0;
      end
`endif
    end else begin
      if (bcd_q != '0) begin
        step_val  = bcd_dec(bcd_q);
        step_term = (step_val == '0);
      end else if (!term_flag) step_term = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      else begin
        step_val  = MAX_BCD;
        step_term = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      bcd_q     <= '0;
      term_flag <= 1'b0;
      tick_q    <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      dir_q <= dir;
      if (clr) begin
        presc     <= '0;
        bcd_q     <= '0;
        term_flag <= 1'b0;
        tick_q    <= 1'b0;
      end else if (load) begin
        presc     <= '0;
        bcd_q     <= load_eff;
        term_flag <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        if (en) begin
          presc  <= presc_wrap ? '0 : presc + 1'b1;
          tick_q <= presc_wrap;
        end else begin
          tick_q <= 1'b0;
        end
        if (step_ok) bcd_q <= step_val;
        if (dir != dir_q) term_flag <= 1'b0;
        else if (step_ok) term_flag <= step_term;
      end
    end
  end

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  // done marks only the edge where the terminal flag rises
  logic done_q;

  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= !clr && !load && (dir == dir_q) && step_ok && step_term && !term_flag;
  end

  assign done = done_q;
`else
  assign done = term_flag;
`endif

  assign bcd  = bcd_q;
  assign tick = tick_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_dec u_dec (
      .bcd (bcd_q[4*g +: 4]),
      .seg (seg[7*g +: 7])
    );
  end

endmodule

// File: doc/bcd_timer.md
Name: bcd_timer

Overview:
- Parametrised N-digit BCD up/down timer with an internal clock-enable prescaler.
- Drives per-digit 7-segment patterns and a terminal/done flag.
- Successor to the fixed 2-digit 0–99 counter:
  - single clock domain (no derived clock);
  - runtime load value and count direction;
  - configurable digit count, limit and tick rate.
- Sits between board switches/buttons and the seven-segment display pins.

Parameters:
- DIGITS, 2, number of BCD digits (1..8).
- DIV, 6000000, clk cycles per count tick (>=1).
- MAX_COUNT, 99, decimal terminal value in up mode; must be < 10**DIGITS.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; 0 freezes prescaler and value
- clr  in  1  synchronous clear, value to 0
- dir  in  1  0 = count up toward MAX_COUNT, 1 = count down toward 0
- load  in  1  load load_val
- load_val  in  4*DIGITS  BCD load value; digit 0 at [3:0]
- bcd  out  4*DIGITS  current value, BCD; digit 0 = ones
- seg  out  7*DIGITS  active-low segments per digit, bit order g..a (bit 6 = g), digit 0 at [6:0]
- done  out  1  terminal reached flag
- tick  out  1  one-cycle pulse when the prescaler fires

Behaviour:
- Reset: bcd = 0, done = 0, tick = 0, prescaler = 0. seg is the decode of 0 on every digit.
- Priority per clk edge: rst > clr > load > tick-step.
- Prescaler:
  - Counts 0..DIV-1 only while en = 1; holds otherwise.
  - tick = 1 in the cycle the prescaler wraps from DIV-1 to 0.
  - DIV = 1 gives a tick every enabled cycle.
  - clr and load reset the prescaler to 0.
- clr: bcd <= 0, done <= 0. clr is not gated by en.
- load:
  - Each digit > 9 in load_val is saturated to 9.
  - In up mode, a value greater than MAX_COUNT is clamped to MAX_COUNT.
  - done <= 0. load is not gated by en.
- Step on tick, terminal T = MAX_COUNT (dir = 0) or 0 (dir = 1):
  - bcd != T: step ±1 with per-digit BCD carry/borrow (9→0 carries up, 0→9 borrows down). If the new value == T, done <= 1 in the same edge.
  - bcd == T and done = 0: no step, done <= 1.
  - bcd == T and done = 1: hold (without AUTO_RELOAD_EN).
- dir change mid-count: takes effect on the next tick. done is cleared on the edge dir changes, unless clr/load/rst also occur.
- Up mode with bcd > MAX_COUNT (only reachable by a dir change): the next tick loads MAX_COUNT and sets done.
- seg: combinational decode of the bcd register.
  - Zero latency to bcd; bcd updates one edge after tick.
  - Codes 0–9 display digits; unreachable codes blank (7'h7F).
- All outputs change only on clk edges; there are no combinational paths from inputs to outputs except through registers.

Optional Feature:
- Macro: BCD_TIMER_AUTO_RELOAD_EN.
- Defined:
  - On a tick at T with done = 1, the value reloads: 0 in up mode, MAX_COUNT in down mode.
  - done becomes a one-cycle pulse per terminal crossing instead of sticky.
  - Counting continues freely.
- Undefined: done is sticky and the value holds at T until clr/load/rst/dir change.

Decomposition:
- Package bcd_timer_pkg:
  - SEG_BLANK constant and the 10 active-low digit patterns;
  - function to_bcd(int, DIGITS) for MAX_COUNT conversion;
  - localparam width helpers (prescaler width = $clog2(DIV)).
- Sub-module seg7_dec: 4-bit BCD in, 7-bit active-low out, purely combinational, instantiated DIGITS times via generate.
- The prescaler and BCD step logic stay in bcd_timer.

Test Plan:
- Reset/idle. Setup: DIGITS=2, DIV=4; rst for 2 cycles, then en=1, dir=0. Expect bcd = 8'h00, seg = {7'h40, 7'h40}, and tick every 4th cycle. After 10 ticks, bcd = 8'h10.
- Up terminal. Setup: MAX_COUNT=12, en=1 from 0. Expect bcd = 8'h12 and done = 1 after 12 ticks; further ticks hold 8'h12 with done = 1. With AUTO_RELOAD_EN, tick 13 gives 8'h00 with done pulsed for 1 cycle.
- Down borrow. Setup: load 8'h20, dir=1. Expect the sequence 20→19→…→00, then done = 1. Load 8'h1F: bcd = 8'h19.
- Clamp/pause. Setup: load 8'h99 with MAX_COUNT=12, dir=0. Expect bcd = 8'h12. Drop en for 10 cycles: bcd and prescaler hold, tick = 0.
- Priority. Setup: clr, load and tick in the same cycle. Expect bcd = 0. Then load and tick in the same cycle: expect bcd = load_val, no step, prescaler = 0.
- Reset mid-count. Setup: rst asserted at bcd = 8'h07 mid-prescale. Expect everything zero the next edge; counting restarts with a full DIV period before the first tick.
